// File: rtl/lsu_if.sv
// lsu_if: memory-side bus between the load/store unit and the data memory.
//   mem_req   : request, held until mem_ready is seen
//   mem_we    : write enable
//   mem_addr  : word-aligned address
//   mem_wstrb : byte-lane write strobes (0 on loads)
//   mem_wdata : lane-replicated store data
//   mem_ready : accept/response strobe from memory
//   mem_rdata : read data, valid while mem_ready=1
// Modports: master = LSU side, slave = memory side.
interface lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// lsu: RV32I load/store unit. Accepts one request per start pulse, checks
// alignment and width code, runs a single bus transaction and returns a
// sign/zero-extended load value with a one-cycle done pulse.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, we, funct3   : request pulse, store/load select, width/sign code
//   addr, wdata         : byte address, store source
//   load_result         : extended load value, held until the next load
//   done, fault, busy   : completion pulse, fault flag (valid with done), busy
//   bus                 : memory bus (lsu_if master)
//
// state  | meaning
// IDLE   | waiting for start
// ACCESS | bus request outstanding, waiting for mem_ready
// RESP   | done pulse (fault or completed access)
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] load_result,
    output logic        done,
    output logic        fault,
    output logic        busy,
    lsu_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        req_fault;
    logic [3:0]  strb_n;
    logic [31:0] wdata_n;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Request decode: fault check, strobes and replicated store data.
    always_comb begin
        req_fault = 1'b0;
        case (funct3)
            3'b000:  req_fault = 1'b0;
            3'b001:  req_fault = addr[0];
            3'b010:  req_fault = addr[1] | addr[0];
            3'b100:  req_fault = we;
            3'b101:  req_fault = we | addr[0];
            default: req_fault = 1'b1;
        endcase

        strb_n  = 4'b0000;
        wdata_n = 32'h0;
        if (we) begin
            case (funct3[1:0])
                2'b00: begin
                    strb_n  = 4'b0001 << addr[1:0];
                    wdata_n = {4{wdata[7:0]}};
                end
                2'b01: begin
                    strb_n  = 4'b0011 << addr[1:0];
                    wdata_n = {2{wdata[15:0]}};
                end
                default: begin
                    strb_n  = 4'b1111;
                    wdata_n = wdata;
                end
            endcase
        end
    end

    // Load extraction from the latched byte offset and width code.
    always_comb begin
        lane = bus.mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            load_result   <= 32'h0;
            done          <= 1'b0;
            fault         <= 1'b0;
            busy          <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wstrb <= 4'b0000;
            bus.mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (req_fault) begin
                            // Faulting requests never touch the bus.
                            state <= RESP;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state         <= ACCESS;
                            we_q          <= we;
                            funct3_q      <= funct3;
                            off_q         <= addr[1:0];
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= we;
                            bus.mem_addr  <= {addr[31:2], 2'b00};
                            bus.mem_wstrb <= strb_n;
                            bus.mem_wdata <= wdata_n;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        state       <= RESP;
                        done        <= 1'b1;
                        fault       <= 1'b0;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        if (!we_q) begin
                            load_result <= load_ext;
                        end
                    end
                end
                RESP: begin
                    // start is ignored here; the done cycle never chains.
                    state <= IDLE;
                    done  <= 1'b0;
                    fault <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    fault       <= 1'b0;
                    busy        <= 1'b0;
                    bus.mem_req <= 1'b0;
                    bus.mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven and randomized checks of the lsu against a
// byte-arithmetic reference model.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load_result;
    logic        done;
    logic        fault;
    logic        busy;

    lsu_if bus();

    lsu dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .we          (we),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .load_result (load_result),
        .done        (done),
        .fault       (fault),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_load = 32'h0;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
        bit          flt;
        logic [3:0]  strb;
        logic [31:0] wdo;
        logic [31:0] res;
        bit          upd;
    } vec_t;

    vec_t tbl[14];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: works on byte positions and integer arithmetic.
    function automatic void ref_op(input logic w, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd, output bit flt,
                                   output logic [3:0] strb, output logic [31:0] wdo,
                                   output logic [31:0] res);
        int     size;
        int     off;
        longint v;
        off = int'(a & 32'd3);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        flt  = (size == 0) || (w && f3[2]) || ((size != 0) && (off % size != 0));
        strb = 4'b0000;
        wdo  = 32'h0;
        res  = 32'h0;
        if (!flt && w) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) strb[i] = 1'b1;
                wdo[8*i +: 8] = wd[8*(i % size) +: 8];
            end
        end
        if (!flt && !w) begin
            v = longint'(rd) >> (8 * off);
            v = v % (longint'(1) << (8 * size));
            if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            res = v[31:0];
        end
    endfunction

    task automatic exec(input string nm, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int dly, input bit poke, input bit start_at_done,
                        input bit flt, input logic [3:0] strb, input logic [31:0] wdo,
                        input logic [31:0] res_new, input bit upd);
        logic [31:0] exp_res;
        exp_res = upd ? res_new : last_load;
        we = w; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
        tick;
        start = 1'b0;
        we = ~w; addr = $urandom; wdata = $urandom;
        if (flt) begin
            chk({nm, " fdone"}, {31'b0, done}, 32'd1);
            chk({nm, " fault"}, {31'b0, fault}, 32'd1);
            chk({nm, " freq"}, {31'b0, bus.mem_req}, 32'd0);
            chk({nm, " fres"}, load_result, exp_res);
        end else begin
            chk({nm, " req"}, {31'b0, bus.mem_req}, 32'd1);
            chk({nm, " addr"}, bus.mem_addr, {a[31:2], 2'b00});
            chk({nm, " we"}, {31'b0, bus.mem_we}, {31'b0, w});
            chk({nm, " strb"}, {28'b0, bus.mem_wstrb}, {28'b0, strb});
            if (w) chk({nm, " wdata"}, bus.mem_wdata, wdo);
            chk({nm, " busy"}, {31'b0, busy}, 32'd1);
            chk({nm, " early"}, {31'b0, done}, 32'd0);
            for (int i = 0; i < dly; i++) begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                if (poke) begin
                    start = 1'b1; we = $urandom_range(0, 1); funct3 = 3'b010;
                    addr = $urandom & 32'hFFFF_FFFC;
                end
                tick;
                start = 1'b0;
                chk({nm, " wreq"}, {31'b0, bus.mem_req}, 32'd1);
                chk({nm, " waddr"}, bus.mem_addr, {a[31:2], 2'b00});
                chk({nm, " wstrb"}, {28'b0, bus.mem_wstrb}, {28'b0, strb});
                chk({nm, " wdone"}, {31'b0, done}, 32'd0);
            end
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rd;
            tick;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            chk({nm, " done"}, {31'b0, done}, 32'd1);
            chk({nm, " nofault"}, {31'b0, fault}, 32'd0);
            chk({nm, " reqoff"}, {31'b0, bus.mem_req}, 32'd0);
            chk({nm, " result"}, load_result, exp_res);
        end
        if (start_at_done) begin
            start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h40;
        end
        tick;
        start = 1'b0;
        chk({nm, " pulse"}, {31'b0, done}, 32'd0);
        chk({nm, " idle"}, {31'b0, busy}, 32'd0);
        chk({nm, " idlereq"}, {31'b0, bus.mem_req}, 32'd0);
        chk({nm, " hold"}, load_result, exp_res);
        last_load = exp_res;
    endtask

    initial begin
        bit          m_flt;
        logic [3:0]  m_strb;
        logic [31:0] m_wdo;
        logic [31:0] m_res;
        logic        rw;
        logic [2:0]  rf3;
        logic [31:0] ra, rwd, rrd;

        //              w     f3      addr          wdata         rdata    dly flt strb     wdata_out     result        upd
        tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b1};
        tbl[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b1};
        tbl[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, 4'b0000, 32'h0, 32'h00000080, 1'b1};
        tbl[3]  = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 0, 1'b0, 4'b0000, 32'h0, 32'h00008011, 1'b1};
        tbl[4]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0};
        tbl[6]  = '{1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 2, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0};
        tbl[7]  = '{1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 3, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0};
        tbl[8]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFF8011, 1'b1};
        tbl[9]  = '{1'b0, 3'b001, 32'h100, 32'h0, 32'h1234F00D, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFFF00D, 1'b1};
        tbl[10] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0};
        tbl[11] = '{1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 3'b101, 32'h103, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0};
        tbl[13] = '{1'b0, 3'b000, 32'h100, 32'h0, 32'h0000007F, 0, 1'b0, 4'b0000, 32'h0, 32'h0000007F, 1'b1};

        rst = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        tick;
        tick;
        chk("rst load_result", load_result, 32'h0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst fault", {31'b0, fault}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst mem_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst mem_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 14; i++) begin
            exec($sformatf("vec%0d", i), tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd,
                 tbl[i].dly, 1'b0, 1'b0, tbl[i].flt, tbl[i].strb, tbl[i].wdo, tbl[i].res, tbl[i].upd);
        end

        // Long wait with a second start during it; start also pulsed in the done cycle.
        exec("wait5", 1'b0, 3'b010, 32'h600, 32'h0, 32'h13579BDF, 5, 1'b1, 1'b1,
             1'b0, 4'b0000, 32'h0, 32'h13579BDF, 1'b1);
        exec("fault_dn", 1'b0, 3'b001, 32'h601, 32'h0, 32'h0, 0, 1'b0, 1'b1,
             1'b1, 4'b0000, 32'h0, 32'h0, 1'b0);

        // Reset in the second ACCESS cycle aborts the access.
        we = 1'b0; funct3 = 3'b010; addr = 32'h500; start = 1'b1;
        tick;
        start = 1'b0;
        chk("abort req1", {31'b0, bus.mem_req}, 32'd1);
        tick;
        chk("abort req2", {31'b0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort req", {31'b0, bus.mem_req}, 32'd0);
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort done", {31'b0, done}, 32'd0);
        chk("abort result", load_result, 32'h0);
        last_load = 32'h0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("abort nodone", {31'b0, done}, 32'd0);
            chk("abort noreq", {31'b0, bus.mem_req}, 32'd0);
        end
        bus.mem_ready = 1'b0;

        // Reset dominates a simultaneous start.
        rst = 1'b1; start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h700;
        tick;
        rst = 1'b0; start = 1'b0;
        chk("rst+start busy", {31'b0, busy}, 32'd0);
        chk("rst+start req", {31'b0, bus.mem_req}, 32'd0);
        tick;
        chk("rst+start busy2", {31'b0, busy}, 32'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rwd = $urandom;
            rrd = $urandom;
            ref_op(rw, rf3, ra, rwd, rrd, m_flt, m_strb, m_wdo, m_res);
            exec($sformatf("rnd%0d", i), rw, rf3, ra, rwd, rrd, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 m_flt, m_strb, m_wdo, m_res, !rw && !m_flt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
